// File: rtl/lut_eval_arbiter_if.sv
// Bus interface for lut_eval_arbiter: config write port, requester side and
// result side. The slave modport is the evaluator; the master modport is the
// client (control logic / testbench).
// Optional feature macro: LUT_EVAL_CARRY_EN adds req_cin / rsp_cout.
interface lut_eval_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NSLOT = 8
);
    localparam int SW = $clog2(NSLOT);
    localparam int IW = $clog2(NREQ);

    // Configuration port
    logic              cfg_we;
    logic [SW-1:0]     cfg_addr;
    logic [15:0]       cfg_data;
    logic              cfg_ready;

    // Requester side
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*SW-1:0] req_slot;
    logic [NREQ*4-1:0]  req_in;
    logic [NREQ-1:0]    req_ready;

    // Result side
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic              rsp_o;

`ifdef LUT_EVAL_CARRY_EN
    logic [NREQ-1:0]   req_cin;
    logic              rsp_cout;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, req_valid, req_slot, req_in, rsp_ready, req_cin,
        output cfg_ready, req_ready, rsp_valid, rsp_id, rsp_o, rsp_cout
    );
    modport master (
        output cfg_we, cfg_addr, cfg_data, req_valid, req_slot, req_in, rsp_ready, req_cin,
        input  cfg_ready, req_ready, rsp_valid, rsp_id, rsp_o, rsp_cout
    );
`else
    modport slave (
        input  cfg_we, cfg_addr, cfg_data, req_valid, req_slot, req_in, rsp_ready,
        output cfg_ready, req_ready, rsp_valid, rsp_id, rsp_o
    );
    modport master (
        output cfg_we, cfg_addr, cfg_data, req_valid, req_slot, req_in, rsp_ready,
        input  cfg_ready, req_ready, rsp_valid, rsp_id, rsp_o
    );
`endif
endinterface

// File: rtl/lut_eval_arbiter.sv
// Shared soft-LUT4 evaluator. A runtime-writable table of 16-bit truth tables
// (bit index = {I3,I2,I1,I0}) is evaluated for NREQ requesters through a
// round-robin arbiter, one result per cycle with one cycle of latency.
// After reset the table is cleared one slot per cycle (INIT) before the block
// accepts requests or config writes.
// Optional feature macro: LUT_EVAL_CARRY_EN adds a carry output computed from
// I1, I2 and a per-requester carry-in.
module lut_eval_arbiter #(
    parameter int NREQ  = 4,
    parameter int NSLOT = 8
) (
    input  logic               clk,
    input  logic               reset,
    lut_eval_arbiter_if.slave  bus
);
    localparam int SW = $clog2(NSLOT);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {INIT, RUN, STALL} state_t;

    state_t        state_q;
    logic [SW-1:0] cnt_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          rsp_valid_q;
    logic [IW-1:0] rsp_id_q;
    logic          rsp_o_q;

    // Truth-table storage; no reset, the INIT sweep clears it.
    logic [15:0]   lut_mem_q [NSLOT];

    logic          mem_we;
    logic [SW-1:0] mem_addr;
    logic [15:0]   mem_wdata;

    // Per-requester views of the packed request buses
    logic [SW-1:0] slot_arr [NREQ];
    logic [3:0]    in_arr   [NREQ];

    logic          gnt_found;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cand_idx;
    logic          can_issue;
    logic          xfer;
    logic          lut_bit;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign slot_arr[gi] = bus.req_slot[gi*SW +: SW];
            assign in_arr[gi]   = bus.req_in[gi*4 +: 4];
            assign bus.req_ready[gi] = xfer && (gnt_idx == IW'(gi));
        end
    endgenerate

    // Round-robin search: first valid requester starting at the pointer
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = IW'((32'(ptr_q) + k) % NREQ);
            if (!gnt_found && bus.req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // A grant is issued only outside INIT and when the result register is free
    // or being drained this cycle.
    assign can_issue = (state_q != INIT) && (!rsp_valid_q || bus.rsp_ready);
    assign xfer      = can_issue && gnt_found;
    assign ptr_d     = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    assign lut_bit   = lut_mem_q[slot_arr[gnt_idx]][in_arr[gnt_idx]];

    // Table write source: the clearing sweep in INIT, config writes otherwise
    always_comb begin
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = 16'h0000;
        end else begin
            mem_we    = bus.cfg_we;
            mem_addr  = bus.cfg_addr;
            mem_wdata = bus.cfg_data;
        end
    end

    // Table write port; a same-cycle evaluation still reads the old word
    always_ff @(posedge clk) begin
        if (mem_we) begin
            lut_mem_q[mem_addr] <= mem_wdata;
        end
    end

`ifdef LUT_EVAL_CARRY_EN
    logic rsp_cout_q;
    logic cout_bit;
    logic [3:0] gnt_in;
    assign gnt_in   = in_arr[gnt_idx];
    assign cout_bit = (gnt_in[1] & gnt_in[2]) | ((gnt_in[1] | gnt_in[2]) & bus.req_cin[gnt_idx]);
    assign bus.rsp_cout = rsp_cout_q;

    // Carry result register, loaded alongside rsp_o
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_cout_q <= 1'b0;
        end else if (xfer) begin
            rsp_cout_q <= cout_bit;
        end
    end
`endif

    // Control FSM: table clear sweep, then arbitration and result handshake.
    // STALL marks a cycle where the held result was refused downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_o_q     <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + SW'(1);
                    if (cnt_q == SW'(NSLOT - 1)) begin
                        state_q <= RUN;
                    end
                end
                RUN, STALL: begin
                    if (xfer) begin
                        ptr_q       <= ptr_d;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= gnt_idx;
                        rsp_o_q     <= lut_bit;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                    state_q <= (rsp_valid_q && !bus.rsp_ready) ? STALL : RUN;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.cfg_ready = (state_q != INIT);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_o     = rsp_o_q;

endmodule

// File: tb/tb_lut_eval_arbiter.sv
// Directed testbench for lut_eval_arbiter: reset/INIT sweep, basic evaluation,
// round-robin order, stall handling, write/eval collision, reset with a
// pending result and (when LUT_EVAL_CARRY_EN is defined) the carry output.
module tb_lut_eval_arbiter;
    localparam int NREQ  = 4;
    localparam int NSLOT = 8;
    localparam int SW    = $clog2(NSLOT);

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lut_eval_arbiter_if #(.NREQ(NREQ), .NSLOT(NSLOT)) bus ();

    lut_eval_arbiter #(.NREQ(NREQ), .NSLOT(NSLOT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [SW-1:0] slot, input logic [3:0] in_v);
        bus.req_slot[i*SW +: SW] = slot;
        bus.req_in[i*4 +: 4]     = in_v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.req_slot = '0; bus.req_in = '0; bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
`ifdef LUT_EVAL_CARRY_EN
        bus.req_cin = '0;
`endif
        tick(); tick();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); n_fail++; end
        n_checks++; if (bus.cfg_ready !== 1'b0) begin $display("FAIL reset_cfg_ready: got %b want 0", bus.cfg_ready); n_fail++; end
        n_checks++; if (bus.req_ready !== 4'b0000) begin $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); n_fail++; end
        n_checks++; if (bus.rsp_id !== 2'd0) begin $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); n_fail++; end
        n_checks++; if (bus.rsp_o !== 1'b0) begin $display("FAIL reset_rsp_o: got %b want 0", bus.rsp_o); n_fail++; end
        reset = 1'b0;
        for (int k = 1; k <= NSLOT; k++) begin
            tick();
            n_checks++;
            if (bus.cfg_ready !== (k == NSLOT)) begin
                $display("FAIL init_cfg_ready cycle %0d: got %b want %b", k, bus.cfg_ready, (k == NSLOT)); n_fail++;
            end
            if (k < NSLOT) begin
                n_checks++;
                if (bus.req_ready !== 4'b0000) begin $display("FAIL init_req_ready cycle %0d: got %b want 0000", k, bus.req_ready); n_fail++; end
            end
        end
        bus.req_valid = 4'b0000;
        set_req(0, 3'd5, 4'hA);
        bus.req_valid = 4'b0001;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin $display("FAIL zero_eval_ready: got %b want 0001", bus.req_ready); n_fail++; end
        tick();
        bus.req_valid = 4'b0000;
        n_checks++; if (bus.rsp_valid !== 1'b1) begin $display("FAIL zero_eval_valid: got %b want 1", bus.rsp_valid); n_fail++; end
        n_checks++; if (bus.rsp_o !== 1'b0) begin $display("FAIL zero_eval_o: got %b want 0", bus.rsp_o); n_fail++; end
        $display("txn reset: id=%0d o=%b", bus.rsp_id, bus.rsp_o);
    endtask

    task automatic test_basic();
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd3; bus.cfg_data = 16'h8000;
        tick();
        bus.cfg_we = 1'b0;
        set_req(0, 3'd3, 4'hF);
        bus.req_valid = 4'b0001;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin $display("FAIL basic_ready: got %b want 0001", bus.req_ready); n_fail++; end
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b1) begin $display("FAIL basic_valid: got %b want 1", bus.rsp_valid); n_fail++; end
        n_checks++; if (bus.rsp_id !== 2'd0) begin $display("FAIL basic_id: got %0d want 0", bus.rsp_id); n_fail++; end
        n_checks++; if (bus.rsp_o !== 1'b1) begin $display("FAIL basic_o_F: got %b want 1", bus.rsp_o); n_fail++; end
        $display("txn basic in=F: id=%0d o=%b", bus.rsp_id, bus.rsp_o);
        set_req(0, 3'd3, 4'hE);
        tick();
        n_checks++; if (bus.rsp_o !== 1'b0) begin $display("FAIL basic_o_E: got %b want 0", bus.rsp_o); n_fail++; end
        $display("txn basic in=E: id=%0d o=%b", bus.rsp_id, bus.rsp_o);
        bus.req_valid = 4'b0000;
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin $display("FAIL basic_clear: got %b want 0", bus.rsp_valid); n_fail++; end
    endtask

    task automatic test_round_robin();
        int ids [6] = '{3, 0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            bus.req_valid = (k == 0) ? 4'b1000 : 4'b1111;
            #1;
            n_checks++;
            if (bus.req_ready !== (4'b0001 << ids[k])) begin
                $display("FAIL rr_ready step %0d: got %b want %b", k, bus.req_ready, (4'b0001 << ids[k])); n_fail++;
            end
            tick();
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(ids[k])) begin
                $display("FAIL rr_id step %0d: got valid=%b id=%0d want valid=1 id=%0d", k, bus.rsp_valid, bus.rsp_id, ids[k]); n_fail++;
            end
            $display("txn rr step %0d: id=%0d", k, bus.rsp_id);
        end
    endtask

    task automatic test_stall();
        bus.rsp_ready = 1'b0;
        set_req(1, 3'd6, 4'h0);
        bus.req_valid = 4'b0010;
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd6; bus.cfg_data = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (bus.req_ready !== 4'b0000) begin $display("FAIL stall_ready cycle %0d: got %b want 0000", k, bus.req_ready); n_fail++; end
            tick();
            bus.cfg_we = 1'b0;
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_o !== 1'b0) begin
                $display("FAIL stall_hold cycle %0d: got valid=%b id=%0d o=%b want 1/0/0", k, bus.rsp_valid, bus.rsp_id, bus.rsp_o); n_fail++;
            end
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) begin $display("FAIL stall_release_ready: got %b want 0010", bus.req_ready); n_fail++; end
        tick();
        bus.req_valid = 4'b0000;
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_o !== 1'b1) begin
            $display("FAIL stall_release_rsp: got valid=%b id=%0d o=%b want 1/1/1", bus.rsp_valid, bus.rsp_id, bus.rsp_o); n_fail++;
        end
        $display("txn stall release: id=%0d o=%b", bus.rsp_id, bus.rsp_o);
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin $display("FAIL stall_clear: got %b want 0", bus.rsp_valid); n_fail++; end
    endtask

    task automatic test_collision();
        set_req(2, 3'd2, 4'h5);
        bus.req_valid = 4'b0100;
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_data = 16'hFFFF;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0100) begin $display("FAIL coll_ready: got %b want 0100", bus.req_ready); n_fail++; end
        tick();
        bus.cfg_we = 1'b0;
        n_checks++;
        if (bus.rsp_id !== 2'd2 || bus.rsp_o !== 1'b0) begin
            $display("FAIL coll_old: got id=%0d o=%b want id=2 o=0", bus.rsp_id, bus.rsp_o); n_fail++;
        end
        $display("txn collision same-cycle: id=%0d o=%b", bus.rsp_id, bus.rsp_o);
        tick();
        n_checks++;
        if (bus.rsp_id !== 2'd2 || bus.rsp_o !== 1'b1) begin
            $display("FAIL coll_new: got id=%0d o=%b want id=2 o=1", bus.rsp_id, bus.rsp_o); n_fail++;
        end
        $display("txn collision next: id=%0d o=%b", bus.rsp_id, bus.rsp_o);
        bus.req_valid = 4'b0000;
        tick();
    endtask

`ifdef LUT_EVAL_CARRY_EN
    task automatic test_carry();
        set_req(0, 3'd0, 4'b0010);
        bus.req_cin = 4'b0001;
        bus.req_valid = 4'b0001;
        tick();
        n_checks++; if (bus.rsp_cout !== 1'b1) begin $display("FAIL carry_cin1: got %b want 1", bus.rsp_cout); n_fail++; end
        $display("txn carry I1=1 I2=0 cin=1: cout=%b", bus.rsp_cout);
        bus.req_cin = 4'b0000;
        tick();
        n_checks++; if (bus.rsp_cout !== 1'b0) begin $display("FAIL carry_cin0: got %b want 0", bus.rsp_cout); n_fail++; end
        $display("txn carry I1=1 I2=0 cin=0: cout=%b", bus.rsp_cout);
        set_req(0, 3'd0, 4'b0110);
        tick();
        n_checks++; if (bus.rsp_cout !== 1'b1) begin $display("FAIL carry_gen: got %b want 1", bus.rsp_cout); n_fail++; end
        bus.req_valid = 4'b0000;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        set_req(1, 3'd3, 4'hF);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 4'b0000;
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_o !== 1'b1) begin
            $display("FAIL mid_pending: got valid=%b o=%b want 1/1", bus.rsp_valid, bus.rsp_o); n_fail++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin $display("FAIL mid_drop: got %b want 0", bus.rsp_valid); n_fail++; end
        n_checks++; if (bus.cfg_ready !== 1'b0) begin $display("FAIL mid_cfg_ready: got %b want 0", bus.cfg_ready); n_fail++; end
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < NSLOT; k++) tick();
        n_checks++; if (bus.cfg_ready !== 1'b1) begin $display("FAIL mid_reinit: got %b want 1", bus.cfg_ready); n_fail++; end
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_o !== 1'b0) begin
            $display("FAIL mid_cleared: got valid=%b o=%b want 1/0", bus.rsp_valid, bus.rsp_o); n_fail++;
        end
        $display("txn after re-init: id=%0d o=%b", bus.rsp_id, bus.rsp_o);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_collision();
`ifdef LUT_EVAL_CARRY_EN
        test_carry();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
